// File: rtl/angle_rate_mapper_pkg.sv
// Shared constants and handshake state encoding for the angle/rate mapper slice.
package angle_rate_mapper_pkg;

  localparam int unsigned ARM_CHANNELS   = 4;
  localparam int unsigned ARM_REC_W      = 8;
  localparam int unsigned ARM_RATE_W     = 16;
  localparam int unsigned ARM_MAP_SHIFT  = 2;
  localparam int unsigned ARM_MAP_OFFSET = 500;
  localparam int unsigned ARM_SCALE_FRAC = 4;
  localparam logic [3:0]  ARM_OFFSET_MASK = 4'b1110;
  localparam logic [3:0]  ARM_ANGLE_MASK  = 4'b1100;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_RUN    = 4'b0010,
    ST_DRAIN  = 4'b0100,
    ST_COMMIT = 4'b1000
  } arm_state_t;

endpackage

// File: rtl/angle_rate_mapper_if.sv
// Start/active/complete handshake plus packed per-channel buses for the mapper.
interface angle_rate_mapper_if
  import angle_rate_mapper_pkg::*;
#(
  parameter int unsigned CHANNELS = ARM_CHANNELS,
  parameter int unsigned REC_W    = ARM_REC_W,
  parameter int unsigned RATE_W   = ARM_RATE_W
);

  logic                       start_signal;
  logic [CHANNELS*REC_W-1:0]  targets;
  logic [CHANNELS*RATE_W-1:0] actuals;
  logic [CHANNELS*RATE_W-1:0] gains;
  logic [CHANNELS*RATE_W-1:0] limit_max;
  logic [CHANNELS*RATE_W-1:0] limit_min;
  logic [CHANNELS*RATE_W-1:0] rates_out;
  logic [CHANNELS*RATE_W-1:0] angle_errors;
  logic [CHANNELS-1:0]        sat_flags;
  logic                       active_signal;
  logic                       complete_signal;

  modport master (
    output start_signal, targets, actuals, gains, limit_max, limit_min,
    input  rates_out, angle_errors, sat_flags, active_signal, complete_signal
  );

  modport slave (
    input  start_signal, targets, actuals, gains, limit_max, limit_min,
    output rates_out, angle_errors, sat_flags, active_signal, complete_signal
  );

endinterface

// File: rtl/angle_rate_mapper_mul_round_sat.sv
// Two-cycle signed multiply, round-half-up by FRAC bits, and clamp to [in_min, in_max].
module fixed_mul_round_sat #(
  parameter int unsigned W     = 16,
  parameter int unsigned IN_W  = 18,
  parameter int unsigned FRAC  = 4,
  parameter int unsigned TAG_W = 2
) (
  input  logic                    us_clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  input  logic [TAG_W-1:0]        in_tag,
  input  logic signed [IN_W-1:0]  in_m,
  input  logic signed [W-1:0]     in_gain,
  input  logic signed [W-1:0]     in_max,
  input  logic signed [W-1:0]     in_min,
  output logic                    out_valid,
  output logic [TAG_W-1:0]        out_tag,
  output logic [W-1:0]            out_val,
  output logic                    out_sat
);

  localparam int unsigned PW = IN_W + W;
  localparam logic signed [PW-1:0] RND = PW'(2 ** (FRAC - 1));

  logic signed [PW-1:0] prod_q;
  logic signed [PW-1:0] rnd;
  logic signed [PW-1:0] lim_hi;
  logic signed [PW-1:0] lim_lo;
  logic signed [W-1:0]  max_q;
  logic signed [W-1:0]  min_q;
  logic                 v1_q;
  logic [TAG_W-1:0]     tag1_q;
  logic [W-1:0]         sat_val;
  logic                 sat_hit;

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      v1_q      <= 1'b0;
      tag1_q    <= '0;
      prod_q    <= '0;
      max_q     <= '0;
      min_q     <= '0;
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_val   <= '0;
      out_sat   <= 1'b0;
    end else begin
      v1_q      <= in_valid;
      tag1_q    <= in_tag;
      prod_q    <= PW'(in_m) * PW'(in_gain);
      max_q     <= in_max;
      min_q     <= in_min;
      out_valid <= v1_q;
      out_tag   <= tag1_q;
      out_val   <= sat_val;
      out_sat   <= sat_hit;
    end
  end

  // An inverted limit pair (min > max) resolves to the upper limit and counts as clamped.
  always_comb begin
    rnd     = (prod_q + RND) >>> FRAC;
    lim_hi  = PW'(max_q);
    lim_lo  = PW'(min_q);
    sat_val = rnd[W-1:0];
    sat_hit = 1'b0;
    if (lim_lo > lim_hi || rnd > lim_hi) begin
      sat_val = max_q;
      sat_hit = 1'b1;
    end else if (rnd < lim_lo) begin
      sat_val = min_q;
      sat_hit = 1'b1;
    end
  end

endmodule

// File: rtl/angle_rate_mapper.sv
// Multi-channel target-to-rate mapper: snapshot inputs, time-multiplex one channel per
// cycle through map -> multiply -> round/clamp, then commit all channels at once.
module angle_rate_mapper
  import angle_rate_mapper_pkg::*;
#(
  parameter int unsigned         CHANNELS    = ARM_CHANNELS,
  parameter int unsigned         REC_W       = ARM_REC_W,
  parameter int unsigned         RATE_W      = ARM_RATE_W,
  parameter int unsigned         MAP_SHIFT   = ARM_MAP_SHIFT,
  parameter int unsigned         MAP_OFFSET  = ARM_MAP_OFFSET,
  parameter logic [CHANNELS-1:0] OFFSET_MASK = ARM_OFFSET_MASK,
  parameter logic [CHANNELS-1:0] ANGLE_MASK  = ARM_ANGLE_MASK,
  parameter int unsigned         SCALE_FRAC  = ARM_SCALE_FRAC
) (
  input logic                us_clk,
  input logic                resetn,
  angle_rate_mapper_if.slave bus
);

  localparam int unsigned IW = RATE_W + 2;
  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);

  arm_state_t state, state_nxt;

  logic [CHANNELS*REC_W-1:0]  cap_targets;
  logic [CHANNELS*RATE_W-1:0] cap_actuals, cap_gains, cap_max, cap_min;
  logic [CHANNELS*RATE_W-1:0] rate_sh, err_sh, rates_q, errs_q;
  logic [CHANNELS-1:0]        sat_sh, sat_q;
  logic                       complete_q;
  logic [CW-1:0]              ch_cnt;
  logic                       drain_cnt;

  logic                       load, issue, commit, active;
  logic [REC_W-1:0]           tgt_sel;
  logic [RATE_W-1:0]          act_sel;
  logic signed [IW-1:0]       map_m;

  logic                       res_valid;
  logic [CW-1:0]              res_tag;
  logic [RATE_W-1:0]          res_val;
  logic                       res_sat;

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (bus.start_signal) state_nxt = ST_RUN;
      ST_RUN:    if (ch_cnt == LAST_CH) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (drain_cnt) state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = bus.start_signal ? ST_RUN : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    active = (state == ST_RUN) || (state == ST_DRAIN);
    issue  = (state == ST_RUN);
    commit = (state == ST_COMMIT);
    load   = ((state == ST_IDLE) || (state == ST_COMMIT)) && bus.start_signal;
  end

  // S1: map the channel selected by ch_cnt from the snapshot.
  always_comb begin
    tgt_sel = cap_targets[ch_cnt*REC_W +: REC_W];
    act_sel = cap_actuals[ch_cnt*RATE_W +: RATE_W];
    map_m   = IW'(tgt_sel) << MAP_SHIFT;
    if (OFFSET_MASK[ch_cnt]) map_m = map_m - IW'(MAP_OFFSET);
    if (ANGLE_MASK[ch_cnt])  map_m = map_m - {{(IW-RATE_W){act_sel[RATE_W-1]}}, act_sel};
  end

  fixed_mul_round_sat #(
    .W     (RATE_W),
    .IN_W  (IW),
    .FRAC  (SCALE_FRAC),
    .TAG_W (CW)
  ) u_mul (
    .us_clk    (us_clk),
    .resetn    (resetn),
    .in_valid  (issue),
    .in_tag    (ch_cnt),
    .in_m      (map_m),
    .in_gain   (cap_gains[ch_cnt*RATE_W +: RATE_W]),
    .in_max    (cap_max[ch_cnt*RATE_W +: RATE_W]),
    .in_min    (cap_min[ch_cnt*RATE_W +: RATE_W]),
    .out_valid (res_valid),
    .out_tag   (res_tag),
    .out_val   (res_val),
    .out_sat   (res_sat)
  );

  // The error shadow is written at issue; the mapped value is already final there.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      cap_targets <= '0;
      cap_actuals <= '0;
      cap_gains   <= '0;
      cap_max     <= '0;
      cap_min     <= '0;
      ch_cnt      <= '0;
      drain_cnt   <= 1'b0;
      rate_sh     <= '0;
      err_sh      <= '0;
      sat_sh      <= '0;
      rates_q     <= '0;
      errs_q      <= '0;
      sat_q       <= '0;
      complete_q  <= 1'b0;
    end else begin
      complete_q <= commit;
      drain_cnt  <= (state == ST_DRAIN) ? ~drain_cnt : 1'b0;
      if (load) begin
        cap_targets <= bus.targets;
        cap_actuals <= bus.actuals;
        cap_gains   <= bus.gains;
        cap_max     <= bus.limit_max;
        cap_min     <= bus.limit_min;
        ch_cnt      <= '0;
      end else if (issue) begin
        ch_cnt <= ch_cnt + 1'b1;
      end
      if (issue) err_sh[ch_cnt*RATE_W +: RATE_W] <= map_m[RATE_W-1:0];
      if (res_valid) begin
        rate_sh[res_tag*RATE_W +: RATE_W] <= res_val;
        sat_sh[res_tag]                   <= res_sat;
      end
      if (commit) begin
        rates_q <= rate_sh;
        errs_q  <= err_sh;
        sat_q   <= sat_sh;
      end
    end
  end

  assign bus.rates_out       = rates_q;
  assign bus.angle_errors    = errs_q;
  assign bus.sat_flags       = sat_q;
  assign bus.active_signal   = active;
  assign bus.complete_signal = complete_q;

endmodule

// File: tb/tb_angle_rate_mapper.sv
// Self-checking bench for angle_rate_mapper: directed cases plus randomized conversions
// checked against an arithmetic reference model.
module tb_angle_rate_mapper;

  localparam int NCH = 4;
  localparam logic [3:0] OFS_MASK = 4'b1110;
  localparam logic [3:0] ANG_MASK = 4'b1100;

  logic us_clk = 1'b0;
  logic resetn;
  int   n_cmp = 0;
  int   n_bad = 0;

  int tgt[NCH];
  int act[NCH];
  int gain[NCH];
  int lmax[NCH];
  int lmin[NCH];

  logic [63:0] er, ee, a_r, a_e;
  logic [3:0]  es, a_s;
  int          lat, actc, seen;

  angle_rate_mapper_if bus ();

  angle_rate_mapper dut (
    .us_clk (us_clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 us_clk = ~us_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [63:0] r, input logic [63:0] e,
                         input logic [3:0] s);
    chk({tag, "_rates"},  bus.rates_out, r);
    chk({tag, "_errors"}, bus.angle_errors, e);
    chk({tag, "_sat"},    64'(bus.sat_flags), 64'(s));
  endtask

  task automatic drive_cfg();
    for (int c = 0; c < NCH; c++) begin
      bus.targets[c*8 +: 8]     = 8'(tgt[c]);
      bus.actuals[c*16 +: 16]   = 16'(act[c]);
      bus.gains[c*16 +: 16]     = 16'(gain[c]);
      bus.limit_max[c*16 +: 16] = 16'(lmax[c]);
      bus.limit_min[c*16 +: 16] = 16'(lmin[c]);
    end
  endtask

  // Reference: map, scale by gain/16 with round-half-up (floor of x+0.5), clamp.
  task automatic model_calc(output logic [63:0] r_exp, output logic [63:0] e_exp,
                            output logic [3:0] s_exp);
    longint m, p, q;
    r_exp = '0;
    e_exp = '0;
    s_exp = '0;
    for (int c = 0; c < NCH; c++) begin
      m = longint'(tgt[c]) * 4;
      if (OFS_MASK[c]) m = m - 500;
      if (ANG_MASK[c]) m = m - act[c];
      p = m * gain[c];
      q = (p + 8) / 16;
      if ((p + 8) % 16 != 0 && (p + 8) < 0) q = q - 1;
      if (lmin[c] > lmax[c] || q > lmax[c]) begin
        q = lmax[c];
        s_exp[c] = 1'b1;
      end else if (q < lmin[c]) begin
        q = lmin[c];
        s_exp[c] = 1'b1;
      end
      r_exp[c*16 +: 16] = 16'(q);
      e_exp[c*16 +: 16] = 16'(m);
    end
  endtask

  task automatic base_cfg();
    for (int c = 0; c < NCH; c++) begin
      act[c]  = 0;
      gain[c] = 16;
      lmax[c] = (c == 0) ? 32'h0FC0 : 400;
      lmin[c] = (c == 0) ? 0 : -400;
    end
  endtask

  task automatic rand_cfg(input bit full);
    for (int c = 0; c < NCH; c++) begin
      tgt[c]  = int'($urandom_range(0, 255));
      act[c]  = full ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 1600)) - 800;
      gain[c] = full ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 96)) - 32;
      lmax[c] = int'($urandom_range(0, 2400)) - 600;
      lmin[c] = int'($urandom_range(0, 2400)) - 1800;
    end
  endtask

  task automatic start_conv();
    @(negedge us_clk);
    drive_cfg();
    bus.start_signal = 1'b1;
    @(posedge us_clk);
    #1;
  endtask

  // Called one step after a start edge; returns cycles to complete (-1 on timeout).
  task automatic wait_done(output int l, output int a);
    l = -1;
    a = 0;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) begin
        @(posedge us_clk);
        #1;
        if (bus.complete_signal) begin
          l = i;
          break;
        end
      end
      if (bus.active_signal) a++;
    end
  endtask

  task automatic conv_check(input string tag);
    start_conv();
    bus.start_signal = 1'b0;
    model_calc(er, ee, es);
    wait_done(lat, actc);
    chk({tag, "_latency"}, lat, 7);
    chk({tag, "_active_cycles"}, actc, 6);
    chk_out(tag, er, ee, es);
    @(posedge us_clk);
    #1;
    chk({tag, "_complete_width"}, bus.complete_signal, 0);
  endtask

  initial begin
    resetn = 1'b0;
    bus.start_signal = 1'b0;
    bus.targets = '0;
    bus.actuals = '0;
    bus.gains = '0;
    bus.limit_max = '0;
    bus.limit_min = '0;
    repeat (3) @(posedge us_clk);
    #1;
    chk("reset_rates", bus.rates_out, 0);
    chk("reset_errors", bus.angle_errors, 0);
    chk("reset_sat", bus.sat_flags, 0);
    chk("reset_active", bus.active_signal, 0);
    chk("reset_complete", bus.complete_signal, 0);
    @(negedge us_clk);
    resetn = 1'b1;

    base_cfg();
    tgt = '{250, 125, 125, 125};
    conv_check("t1");
    chk("t1_throttle", bus.rates_out[15:0], 16'h03E8);
    chk("t1_yaw", bus.rates_out[31:16], 16'h0000);
    chk("t1_satflags", bus.sat_flags, 4'b0000);

    base_cfg();
    tgt = '{250, 250, 150, 0};
    act[2] = 32'h0040;
    act[3] = 32'h0190;
    gain[2] = 32'h0020;
    conv_check("t234");
    chk("t2_yaw_rate", bus.rates_out[31:16], 16'h0190);
    chk("t2_yaw_err", bus.angle_errors[31:16], 16'h01F4);
    chk("t3_pitch_err", bus.angle_errors[47:32], 16'h0024);
    chk("t3_pitch_rate", bus.rates_out[47:32], 16'h0048);
    chk("t4_roll_err", bus.angle_errors[63:48], 16'hFC7C);
    chk("t4_roll_rate", bus.rates_out[63:48], 16'hFE70);
    chk("t234_satflags", bus.sat_flags, 4'b1010);

    // Back-to-back: start held high, inputs changed mid-conversion.
    rand_cfg(1'b0);
    start_conv();
    model_calc(a_r, a_e, a_s);
    repeat (2) begin
      @(posedge us_clk);
      #1;
    end
    rand_cfg(1'b0);
    drive_cfg();
    lat = -1;
    for (int i = 3; i < 30; i++) begin
      @(posedge us_clk);
      #1;
      if (bus.complete_signal) begin
        lat = i;
        break;
      end
    end
    chk("b2b_a_latency", lat, 7);
    chk_out("b2b_a", a_r, a_e, a_s);
    model_calc(er, ee, es);
    wait_done(lat, actc);
    chk("b2b_b_latency", lat, 7);
    chk("b2b_b_active_cycles", actc, 6);
    chk_out("b2b_b", er, ee, es);
    bus.start_signal = 1'b0;
    wait_done(lat, actc);
    chk("b2b_c_latency", lat, 7);
    chk_out("b2b_c", er, ee, es);

    for (int n = 0; n < 14; n++) begin
      rand_cfg(n % 3 == 0);
      conv_check($sformatf("rnd%0d", n));
    end

    // Reset asserted while draining aborts the conversion.
    rand_cfg(1'b0);
    start_conv();
    bus.start_signal = 1'b0;
    repeat (4) @(posedge us_clk);
    #1;
    resetn = 1'b0;
    #1;
    chk("rst_rates", bus.rates_out, 0);
    chk("rst_errors", bus.angle_errors, 0);
    chk("rst_sat", bus.sat_flags, 0);
    chk("rst_active", bus.active_signal, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin
        @(negedge us_clk);
        resetn = 1'b1;
      end
      @(posedge us_clk);
      #1;
      if (bus.complete_signal) seen = 1;
    end
    chk("rst_no_complete", seen, 0);
    rand_cfg(1'b0);
    conv_check("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
